// File: rtl/key_pkg.sv
// Shared constants for the key debounce block and its benches.
//   KEY_NUM_DEF         : default number of keys on the board
//   DEBOUNCE_CYCLES_SIM : short stability window used by simulation benches
//   DEBOUNCE_CYCLES_50M : 20 ms stability window at a 50 MHz clock
package key_pkg;

    localparam int unsigned KEY_NUM_DEF         = 8;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 16;
    localparam int unsigned DEBOUNCE_CYCLES_50M = 1_000_000;

    // Width of a counter that must hold values 0 .. cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles);
    endfunction

endpackage : key_pkg

// File: rtl/key_debounce_bit.sv
// Single-key conditioning slice: 2-flop synchroniser, stability counter,
// debounced level register and registered press/release pulses.
// Ports:
//   i_clk     : system clock
//   i_rst     : synchronous active-low reset
//   i_key     : raw asynchronous button pin
//   o_level   : debounced level, active-high (1 = pressed)
//   o_press   : one-cycle pulse when o_level rises
//   o_release : one-cycle pulse when o_level falls
module key_debounce_bit
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_key_norm;
    logic             w_s;
    logic             w_diff;
    logic             w_term;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    // Normalise polarity before synchronising so reset can load 0 as "released".
    assign w_key_norm = KEY_ACTIVE_LOW ? ~i_key : i_key;
    assign w_s        = r_sync[1];
    assign w_diff     = (w_s != r_level);
    assign w_term     = (r_cnt == TERM_CNT);

    // Synchroniser chain.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], w_key_norm};
        end
    end

    // Stability counter, level register and edge pulses. Any return of the
    // synchronised input to the current level clears the count, so a bounce
    // restarts the whole window. Pulses are set in the same edge as the level.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_term) begin
                r_cnt     <= '0;
                r_level   <= w_s;
                r_press   <= w_s;
                r_release <= ~w_s;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : key_debounce_bit

// File: rtl/key_debounce.sv
// Debounces a bus of raw push-buttons; one independent slice per key.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-low reset
//   key_in      : raw asynchronous button pins
//   key_out     : debounced levels, active-high
//   key_press   : one-cycle pulses on released->pressed
//   key_release : one-cycle pulses on pressed->released
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned KEY_NUM         = KEY_NUM_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_out,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release
);

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        key_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
            .CNT_W           (CNT_W)
        ) u_bit (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_key     (key_in[g]),
            .o_level   (key_out[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );
    end

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (16-cycle window, active-high pins).
module tb_key_debounce;
    import key_pkg::*;

    localparam int unsigned KN  = KEY_NUM_DEF;
    localparam int unsigned DC  = DEBOUNCE_CYCLES_SIM;
    localparam int unsigned LAT = DC + 2;

    typedef struct {
        logic [KN-1:0] kin;
        int unsigned   hold;
        logic [KN-1:0] out;
        logic [KN-1:0] press;
        logic [KN-1:0] rel;
    } vec_t;

    typedef struct {
        int unsigned   due;
        logic [KN-1:0] out;
        logic [KN-1:0] press;
        logic [KN-1:0] rel;
    } ev_t;

    logic          clk;
    logic          rst;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_out;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;

    int unsigned   cyc;
    int unsigned   n_checks;
    int unsigned   n_fail;
    logic [KN-1:0] exp_out;
    ev_t           sb[$];
    vec_t          vecs[7];

    key_debounce #(
        .KEY_NUM         (KN),
        .DEBOUNCE_CYCLES (DC),
        .KEY_ACTIVE_LOW  (1'b0),
        .CNT_W           ($clog2(DC))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [KN-1:0] act, input logic [KN-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    // Expect an output change LAT edges after the current drive point.
    task automatic expect_evt(input logic [KN-1:0] out, input logic [KN-1:0] press,
                              input logic [KN-1:0] rel);
        ev_t e;
        e.due   = cyc + LAT;
        e.out   = out;
        e.press = press;
        e.rel   = rel;
        sb.push_back(e);
    endtask

    // Advance one edge, sample 1 ns later and compare against the scoreboard.
    task automatic tick();
        logic [KN-1:0] ep;
        logic [KN-1:0] er;
        @(posedge clk);
        #1;
        cyc++;
        ep = '0;
        er = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            ev_t e;
            e       = sb.pop_front();
            exp_out = e.out;
            ep      = e.press;
            er      = e.rel;
        end
        check("key_out", key_out, exp_out);
        check("key_press", key_press, ep);
        check("key_release", key_release, er);
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        exp_out  = '0;

        // Table: drive, hold, expected result of that drive.
        vecs[0] = '{8'h01, 50, 8'h01, 8'h01, 8'h00};  // clean press bit 0
        vecs[1] = '{8'h00, 50, 8'h00, 8'h00, 8'h01};  // clean release bit 0
        vecs[2] = '{8'h20, 15, 8'h00, 8'h00, 8'h00};  // 15-cycle glitch bit 5
        vecs[3] = '{8'h00, 40, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{8'hF0, 50, 8'hF0, 8'hF0, 8'h00};  // multi-key press
        vecs[5] = '{8'h93, 50, 8'h93, 8'h03, 8'h60};  // mixed press/release
        vecs[6] = '{8'h00, 50, 8'h00, 8'h00, 8'h93};

        // Reset with every key already high.
        rst    = 1'b0;
        key_in = 8'hFF;
        ticks(100);
        rst = 1'b1;
        expect_evt(8'hFF, 8'hFF, 8'h00);
        ticks(60);                              // also covers held key: no repeats
        key_in = 8'h00;
        expect_evt(8'h00, 8'h00, 8'hFF);
        ticks(40);

        for (int i = 0; i < 7; i++) begin
            key_in = vecs[i].kin;
            if ((vecs[i].press | vecs[i].rel) != '0)
                expect_evt(vecs[i].out, vecs[i].press, vecs[i].rel);
            ticks(vecs[i].hold);
        end

        // Bounce on bit 3: toggle every 3 cycles for 60 cycles, then hold high.
        for (int k = 0; k < 20; k++) begin
            key_in = (k % 2 == 0) ? 8'h08 : 8'h00;
            ticks(3);
        end
        key_in = 8'h08;
        expect_evt(8'h08, 8'h08, 8'h00);
        ticks(40);
        key_in = 8'h00;
        expect_evt(8'h00, 8'h00, 8'h08);
        ticks(40);

        // Reset mid-count on bit 7: partial count must be discarded.
        key_in = 8'h80;
        ticks(12);
        rst     = 1'b0;
        exp_out = '0;
        ticks(2);
        rst = 1'b1;
        expect_evt(8'h80, 8'h80, 8'h00);
        ticks(40);
        key_in = 8'h00;
        expect_evt(8'h00, 8'h00, 8'h80);
        ticks(40);

        check("sb_empty", KN'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_debounce
